// File: rtl/ceyloniac_pkg.sv
// Shared definitions for the ceyloniac RAM loader: loader state encoding
// and default RAM geometry.
package ceyloniac_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 16;
    localparam int DEFAULT_DATA_WIDTH = 32;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_VERIFY  = 3'd2,
        ST_RELEASE = 3'd3,
        ST_DONE    = 3'd4
    } loader_state_t;

endpackage

// File: rtl/ceyloniac_loader_addr_gen.sv
// Base+index word address counter for the RAM loader. The address wraps
// modulo 2^ADDR_WIDTH. 'restart' selects index 0 in the same cycle, so a
// restart combined with a step presents the base address and advances to
// index 1. 'last' flags the final word of the captured count; 'all_issued'
// is high once every index has been stepped past.
module ceyloniac_loader_addr_gen
    import ceyloniac_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  capture,
    input  logic [ADDR_WIDTH-1:0] base,
    input  logic [ADDR_WIDTH-1:0] count,
    input  logic                  restart,
    input  logic                  step,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  last,
    output logic                  all_issued
);

    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH-1:0] count_q;
    logic [ADDR_WIDTH-1:0] idx_q;
    logic [ADDR_WIDTH-1:0] idx_eff;

    assign idx_eff    = restart ? '0 : idx_q;
    assign addr       = base_q + idx_eff;
    assign last       = (idx_eff == (count_q - 1'b1));
    assign all_issued = (idx_q == count_q);

    // Capture base/count for a new load, otherwise advance or rewind the index.
    always_ff @(posedge clk) begin
        if (rst) begin
            base_q  <= '0;
            count_q <= '0;
            idx_q   <= '0;
        end else if (capture) begin
            base_q  <= base;
            count_q <= count;
            idx_q   <= '0;
        end else if (step) begin
            idx_q   <= idx_eff + 1'b1;
        end else if (restart) begin
            idx_q   <= '0;
        end
    end

endmodule

// File: rtl/ceyloniac_ram_loader.sv
// Program loader that owns the external port of the RAM controller while a
// host streams words into consecutive addresses, then hands the RAM back and
// pulses processor_start. Optional readback verification is compiled in with
// the CEYLONIAC_LOADER_VERIFY_EN macro. dbg_state exposes the FSM state.
//
// Host handshake: a word transfers on every rising edge where host_valid and
// host_ready are both high. host_ready is registered; it is high throughout
// LOAD until the count-th word has transferred and low in every other state.
// The host may drop host_valid for any number of cycles.
module ceyloniac_ram_loader
    import ceyloniac_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_start,
    input  logic [ADDR_WIDTH-1:0] load_base_addr,
    input  logic [ADDR_WIDTH-1:0] load_count,
    input  logic [DATA_WIDTH-1:0] host_data,
    input  logic                  host_valid,
    output logic                  host_ready,
    output logic                  ram_external_control_enable,
    output logic                  external_ram_enable,
    output logic                  external_ram_write_enable,
    output logic                  external_ram_read_enable,
    output logic [ADDR_WIDTH-1:0] external_ram_addr,
    output logic [DATA_WIDTH-1:0] external_ram_write_data,
    input  logic [DATA_WIDTH-1:0] external_ram_read_data,
    output logic                  load_busy,
    output logic                  load_done,
    output logic                  load_error,
    output logic                  processor_start,
    output logic [2:0]            dbg_state
);

    loader_state_t         state_q, state_d;
    logic                  host_ready_d, ctrl_d, ram_en_d, we_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [DATA_WIDTH-1:0] wdata_d;
    logic                  busy_d, done_d, start_d;
    logic                  ag_capture, ag_restart, ag_step;
    logic [ADDR_WIDTH-1:0] ag_addr;
    logic                  ag_last, ag_all_issued;

`ifdef CEYLONIAC_LOADER_VERIFY_EN
    logic                  re_d, re_q;
    logic                  rd_valid_q;
    logic                  error_d, error_q;
    logic [DATA_WIDTH-1:0] checksum_d, checksum_q;
    logic [DATA_WIDTH-1:0] sum_d, sum_q;

    assign external_ram_read_enable = re_q;
    assign load_error               = error_q;
`else
    logic unused_sigs;

    assign external_ram_read_enable = 1'b0;
    assign load_error               = 1'b0;
    assign unused_sigs              = ^{external_ram_read_data, ag_all_issued};
`endif

    assign dbg_state = state_q;

    ceyloniac_loader_addr_gen #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .capture    (ag_capture),
        .base       (load_base_addr),
        .count      (load_count),
        .restart    (ag_restart),
        .step       (ag_step),
        .addr       (ag_addr),
        .last       (ag_last),
        .all_issued (ag_all_issued)
    );

    // Next state and next registered outputs; every output mirrors the state it is entering.
    always_comb begin
        state_d      = state_q;
        host_ready_d = 1'b0;
        ctrl_d       = 1'b0;
        ram_en_d     = 1'b0;
        we_d         = 1'b0;
        addr_d       = '0;
        wdata_d      = '0;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        start_d      = 1'b0;
        ag_capture   = 1'b0;
        ag_restart   = 1'b0;
        ag_step      = 1'b0;
`ifdef CEYLONIAC_LOADER_VERIFY_EN
        re_d         = 1'b0;
        error_d      = error_q;
        checksum_d   = checksum_q;
        sum_d        = sum_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                done_d = (state_q == ST_DONE);
                if (load_start) begin
                    ag_capture = 1'b1;
                    ctrl_d     = 1'b1;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
`ifdef CEYLONIAC_LOADER_VERIFY_EN
                    error_d    = 1'b0;
                    checksum_d = '0;
                    sum_d      = '0;
`endif
                    if (load_count == '0) begin
                        state_d = ST_RELEASE;
                    end else begin
                        state_d      = ST_LOAD;
                        host_ready_d = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                ctrl_d = 1'b1;
                busy_d = 1'b1;
                if (host_ready) begin
                    host_ready_d = 1'b1;
                    if (host_valid) begin
                        ram_en_d = 1'b1;
                        we_d     = 1'b1;
                        addr_d   = ag_addr;
                        wdata_d  = host_data;
                        ag_step  = 1'b1;
`ifdef CEYLONIAC_LOADER_VERIFY_EN
                        checksum_d = checksum_q + host_data;
`endif
                        if (ag_last) begin
                            host_ready_d = 1'b0;
                        end
                    end
                end else begin
                    // The final write strobe is on the port this cycle.
`ifdef CEYLONIAC_LOADER_VERIFY_EN
                    state_d    = ST_VERIFY;
                    ag_restart = 1'b1;
                    ag_step    = 1'b1;
                    ram_en_d   = 1'b1;
                    re_d       = 1'b1;
                    addr_d     = ag_addr;
`else
                    state_d    = ST_RELEASE;
`endif
                end
            end
`ifdef CEYLONIAC_LOADER_VERIFY_EN
            ST_VERIFY: begin
                ctrl_d = 1'b1;
                busy_d = 1'b1;
                if (!ag_all_issued) begin
                    ram_en_d = 1'b1;
                    re_d     = 1'b1;
                    addr_d   = ag_addr;
                    ag_step  = 1'b1;
                end
                if (rd_valid_q) begin
                    sum_d = sum_q + external_ram_read_data;
                    // No read on the port now means this return is the last one.
                    if (!re_q) begin
                        error_d = ((sum_q + external_ram_read_data) != checksum_q);
                        state_d = ST_RELEASE;
                    end
                end
            end
`endif
            ST_RELEASE: begin
                state_d = ST_DONE;
                start_d = 1'b1;
                done_d  = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset returns the RAM to the processor.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q                     <= ST_IDLE;
            host_ready                  <= 1'b0;
            ram_external_control_enable <= 1'b0;
            external_ram_enable         <= 1'b0;
            external_ram_write_enable   <= 1'b0;
            external_ram_addr           <= '0;
            external_ram_write_data     <= '0;
            load_busy                   <= 1'b0;
            load_done                   <= 1'b0;
            processor_start             <= 1'b0;
        end else begin
            state_q                     <= state_d;
            host_ready                  <= host_ready_d;
            ram_external_control_enable <= ctrl_d;
            external_ram_enable         <= ram_en_d;
            external_ram_write_enable   <= we_d;
            external_ram_addr           <= addr_d;
            external_ram_write_data     <= wdata_d;
            load_busy                   <= busy_d;
            load_done                   <= done_d;
            processor_start             <= start_d;
        end
    end

`ifdef CEYLONIAC_LOADER_VERIFY_EN
    // Readback tracking: data returns one cycle after each read address.
    always_ff @(posedge clk) begin
        if (rst) begin
            re_q       <= 1'b0;
            rd_valid_q <= 1'b0;
            error_q    <= 1'b0;
            checksum_q <= '0;
            sum_q      <= '0;
        end else begin
            re_q       <= re_d;
            rd_valid_q <= re_q;
            error_q    <= error_d;
            checksum_q <= checksum_d;
            sum_q      <= sum_d;
        end
    end
`endif

endmodule

// File: tb/tb_ceyloniac_ram_loader.sv
// Bench for ceyloniac_ram_loader: a driver streams words from a reference
// list, the expected writes go into a queue, and a negedge monitor pops and
// compares every write strobe. A small RAM model answers readbacks and can
// corrupt one address.
module tb_ceyloniac_ram_loader;

    localparam int AW = 16;
    localparam int DW = 32;
`ifdef CEYLONIAC_LOADER_VERIFY_EN
    localparam bit VERIFY_ON = 1'b1;
`else
    localparam bit VERIFY_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load_start = 1'b0;
    logic [AW-1:0] load_base_addr = '0;
    logic [AW-1:0] load_count = '0;
    logic [DW-1:0] host_data = '0;
    logic          host_valid = 1'b0;
    logic          host_ready;
    logic          ctrl_en;
    logic          ram_en, ram_we, ram_re;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata = '0;
    logic          load_busy, load_done, load_error, processor_start;
    logic [2:0]    dbg_state;

    logic [AW+DW-1:0] exp_q[$];
    logic [DW-1:0]    mem [0:(1<<AW)-1];
    logic             corrupt_on = 1'b0;
    logic [AW-1:0]    corrupt_addr = '0;
    int               cyc = 0;
    int               pstart_cnt = 0;
    int               cmp_cnt = 0;
    int               err_cnt = 0;

    ceyloniac_ram_loader dut (
        .clk                         (clk),
        .rst                         (rst),
        .load_start                  (load_start),
        .load_base_addr              (load_base_addr),
        .load_count                  (load_count),
        .host_data                   (host_data),
        .host_valid                  (host_valid),
        .host_ready                  (host_ready),
        .ram_external_control_enable (ctrl_en),
        .external_ram_enable         (ram_en),
        .external_ram_write_enable   (ram_we),
        .external_ram_read_enable    (ram_re),
        .external_ram_addr           (ram_addr),
        .external_ram_write_data     (ram_wdata),
        .external_ram_read_data      (ram_rdata),
        .load_busy                   (load_busy),
        .load_done                   (load_done),
        .load_error                  (load_error),
        .processor_start             (processor_start),
        .dbg_state                   (dbg_state)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM model behind the external port
    always @(posedge clk) begin
        if (ram_en && ram_we) mem[ram_addr] <= ram_wdata;
        if (ram_en && ram_re)
            ram_rdata <= (corrupt_on && ram_addr == corrupt_addr) ? (mem[ram_addr] ^ 32'h1) : mem[ram_addr];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string name);
        check(name, 64'({host_ready, ctrl_en, ram_en, ram_we, ram_re, ram_addr, ram_wdata,
                          load_busy, load_done, load_error, processor_start}), 64'd0);
    endtask

    // Monitor: every write strobe must match the next expected {addr, data}
    always @(negedge clk) begin
        logic [AW+DW-1:0] e;
        if (ram_en && ram_we) begin
            if (exp_q.size() == 0) begin
                cmp_cnt++;
                err_cnt++;
                $display("FAIL unexpected_write: addr %0h data %0h, no write expected", ram_addr, ram_wdata);
            end else begin
                e = exp_q.pop_front();
                check("write", 64'({ctrl_en, ram_addr, ram_wdata}), 64'({1'b1, e}));
            end
        end
        if (processor_start) pstart_cnt++;
    end

    // Driver: one complete load; stall_mode 0 = full rate, 1 = valid 1,0,0,1, 2 = random
    task automatic run_load(input logic [AW-1:0] base, input int cnt, input int stall_mode,
                            input bit seq_words, input bit guard, input bit corrupt, input int abort_after);
        logic [DW-1:0] words[$];
        logic [DW-1:0] w;
        int k, i, budget, n_exp, p0, exp_lat;
        bit found, exp_err;
        n_exp = (abort_after > 0) ? abort_after : cnt;
        exp_q.delete();
        for (int j = 0; j < cnt; j++) begin
            w = seq_words ? DW'(j + 1) : $urandom;
            words.push_back(w);
            if (j < n_exp) exp_q.push_back({base + AW'(j), w});
        end
        corrupt_on   = corrupt;
        corrupt_addr = base + AW'(2);
        exp_err      = corrupt && VERIFY_ON && (cnt >= 3);
        exp_lat      = (cnt == 0) ? 2 : (VERIFY_ON ? 2 * cnt + 4 : cnt + 3);
        p0           = pstart_cnt;

        load_start = 1'b1; load_base_addr = base; load_count = AW'(cnt); k = cyc;
        @(posedge clk); #1;
        load_start = 1'b0; load_base_addr = AW'($urandom); load_count = AW'($urandom);

        i = 0; budget = 0;
        while (i < n_exp && budget < 500) begin
            case (stall_mode)
                0:       host_valid = 1'b1;
                1:       host_valid = (budget % 4 == 0) || (budget % 4 == 3);
                default: host_valid = ($urandom_range(0, 99) >= 30);
            endcase
            host_data = host_valid ? words[i] : $urandom;
            if (guard && i == 2) begin
                load_start = 1'b1; load_base_addr = AW'($urandom); load_count = AW'($urandom_range(1, 3));
            end
            @(negedge clk);
            if (host_valid && host_ready) i++;
            @(posedge clk); #1;
            load_start = 1'b0;
            budget++;
        end
        host_valid = 1'b0;
        check("handshakes", 64'(i), 64'(n_exp));

        if (abort_after > 0) begin
            rst = 1'b1;
            @(negedge clk);
            @(negedge clk);
            check_all_zero("reset_mid_load_outputs");
            check("reset_mid_load_state", 64'(dbg_state), 64'd0);
            @(posedge clk); #1;
            rst = 1'b0;
            repeat (10) @(posedge clk);
            #1;
            check("no_start_after_reset", 64'(pstart_cnt - p0), 64'd0);
            check("writes_before_reset", 64'(exp_q.size()), 64'd0);
        end else begin
            found = 1'b0;
            for (int t = 0; t < 400 && !found; t++) begin
                @(negedge clk);
                if (processor_start) found = 1'b1;
            end
            if (!found) begin
                cmp_cnt++;
                err_cnt++;
                $display("FAIL start_timeout: no processor_start within 400 cycles (count %0d)", cnt);
            end else begin
                if (stall_mode == 0) check("start_latency", 64'(cyc - k), 64'(exp_lat));
                check("ctrl_released_at_start", 64'(ctrl_en), 64'd0);
                @(negedge clk);
                check("done_flags", 64'({load_done, load_busy, processor_start, load_error}),
                      64'({1'b1, 1'b0, 1'b0, exp_err}));
                check("start_pulses", 64'(pstart_cnt - p0), 64'd1);
                check("writes_drained", 64'(exp_q.size()), 64'd0);
            end
            corrupt_on = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset_outputs");
        check("reset_state", 64'(dbg_state), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        run_load(16'h0001, 6, 0, 1'b1, 1'b0, 1'b0, 0);   // basic load, words 1..6
        run_load(16'h0001, 6, 1, 1'b0, 1'b0, 1'b0, 0);   // host stalls 1,0,0,1
        run_load(AW'($urandom), 0, 0, 1'b0, 1'b0, 1'b0, 0); // empty load
        run_load(16'hFFFE, 4, 0, 1'b0, 1'b0, 1'b0, 0);   // address wrap
        run_load(16'h0001, 6, 0, 1'b0, 1'b0, 1'b1, 0);   // corrupt address 3
        run_load(16'h0001, 6, 0, 1'b0, 1'b0, 1'b0, 0);   // clean readback
        run_load(16'h0040, 8, 0, 1'b0, 1'b1, 1'b0, 0);   // load_start during LOAD
        run_load(16'h0010, 6, 0, 1'b0, 1'b0, 1'b0, 3);   // reset after 3rd handshake
        for (int r = 0; r < 5; r++)
            run_load(AW'($urandom), $urandom_range(1, 12), 2, 1'b0, 1'b0, 1'b0, 0);
        run_load(AW'($urandom), 1, 0, 1'b0, 1'b0, 1'b0, 0); // single word

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
